// File: rtl/mu0_param_pkg.sv
// Shared definitions for the parametrised MU0 core: opcodes, FSM states and ALU
// operation selects, plus small decode helpers used by the top level.
package mu0_param_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;
    localparam logic [3:0] OP_AND = 4'h8;
    localparam logic [3:0] OP_OR  = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_SHL = 4'hB;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_SHL  = 3'd5,
        ALU_IMM  = 3'd6
    } alu_op_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic alu_op_t alu_op_for(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SHL:  return ALU_SHL;
            OP_LDI:  return ALU_IMM;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/mu0_param_alu.sv
// Combinational accumulator ALU. Arithmetic wraps at DATA_W bits; there is no
// carry out because the core keeps no carry or overflow flag.
module mu0_param_alu
    import mu0_param_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = B;
        case (op)
            ALU_PASS: result = B;
            ALU_ADD:  result = A + B;
            ALU_SUB:  result = A - B;
            ALU_AND:  result = A & B;
            ALU_OR:   result = A | B;
            ALU_SHL:  result = {A[DATA_W-2:0], 1'b0};
            // B carries the instruction word; keep only the address field
            ALU_IMM:  result = {4'b0000, B[DATA_W-5:0]};
            default:  result = B;
        endcase
    end

endmodule

// File: rtl/mu0_param.sv
// Parametrised MU0 core: single accumulator, fetch/execute FSM, one unified
// memory port with a Mem_ready wait-state handshake. All outputs are Moore.
//
// state | meaning
// FETCH | Rd at PC; on Mem_ready latch IR, bump PC
// EXEC  | memory op waits for Mem_ready; others finish in one cycle
// HALT  | idle with Halted=1 until reset
module mu0_param
    import mu0_param_pkg::*;
#(
    parameter int                DATA_W       = 16,
    parameter logic [DATA_W-5:0] RESET_VECTOR = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              Mem_ready,
    output logic              Rd,
    output logic              Wr,
    output logic [DATA_W-5:0] Addr,
    output logic [DATA_W-1:0] Data_out,
    output logic              Halted
);

    localparam int ADDR_W = DATA_W - 4;

    if (DATA_W < 8 || DATA_W > 32) begin : g_bad_width
        $error("mu0_param: DATA_W must be within 8..32");
    end

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   acc_q, acc_d;

    logic [3:0]          opcode;
    logic [ADDR_W-1:0]   operand;
    logic [DATA_W-1:0]   alu_b;
    logic [DATA_W-1:0]   alu_result;

    assign opcode  = ir_q[DATA_W-1:DATA_W-4];
    assign operand = ir_q[ADDR_W-1:0];
    // LDI takes its operand from IR; every other ALU user reads memory
    assign alu_b   = (opcode == OP_LDI) ? ir_q : Data_in;

    mu0_param_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .A      (acc_q),
        .B      (alu_b),
        .op     (alu_op_for(opcode)),
        .result (alu_result)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_VECTOR;
            ir_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        acc_d    = acc_q;
        Rd       = 1'b0;
        Wr       = 1'b0;
        Addr     = pc_q;
        Halted   = 1'b0;
        Data_out = acc_q;

        case (state_q)
            FETCH: begin
                Rd = 1'b1;
                if (Mem_ready) begin
                    ir_d    = Data_in;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = EXEC;
                end
            end

            EXEC: begin
                Addr = operand;
                if (is_mem_op(opcode)) begin
                    Rd = (opcode != OP_STA);
                    Wr = (opcode == OP_STA);
                    if (Mem_ready) begin
                        if (opcode != OP_STA) begin
                            acc_d = alu_result;
                        end
                        state_d = FETCH;
                    end
                end else begin
                    state_d = FETCH;
                    case (opcode)
                        OP_JMP: pc_d = operand;
                        OP_JGE: if (!acc_q[DATA_W-1]) pc_d = operand;
                        OP_JNE: if (acc_q != '0) pc_d = operand;
                        OP_STP: state_d = HALT;
                        OP_LDI: acc_d = alu_result;
                        OP_SHL: acc_d = alu_result;
                        default: ;
                    endcase
                end
            end

            HALT: begin
                Halted = 1'b1;
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mu0_param.sv
// Directed bench for mu0_param: a 16-bit core (reset vector 0x010) and an 8-bit
// core (reset vector 0xC) each driven by a small wait-state memory model.
module tb_mu0_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- 16-bit core ----------------
    logic        reset_16;
    logic [15:0] din_16, dout_16;
    logic        rdy_16, rd_16, wr_16, halted_16;
    logic [11:0] addr_16;
    logic [15:0] mem16 [0:4095];
    int          wait_16 = 0;
    int          cnt_16  = 0;

    mu0_param #(.DATA_W(16), .RESET_VECTOR(12'h010)) dut16 (
        .Clk(clk), .Reset(reset_16), .Data_in(din_16), .Mem_ready(rdy_16),
        .Rd(rd_16), .Wr(wr_16), .Addr(addr_16), .Data_out(dout_16),
        .Halted(halted_16)
    );

    assign rdy_16 = (rd_16 | wr_16) && (cnt_16 == wait_16);
    assign din_16 = mem16[addr_16];

    always @(posedge clk) begin
        if (!reset_16)          cnt_16 <= 0;
        else if (rd_16 | wr_16) cnt_16 <= rdy_16 ? 0 : cnt_16 + 1;
    end

    int          wrdone_16 = 0, wrcyc_16 = 0, both_16 = 0, unstable_16 = 0;
    logic [11:0] wr_addr_16 = '0;
    logic [15:0] wr_data_16 = '0;
    logic        prev_wait_16 = 1'b0;
    logic [29:0] prev_bus_16 = '0;

    always @(negedge clk) begin
        #1;
        if (rd_16 && wr_16) both_16++;
        if (wr_16) wrcyc_16++;
        if (reset_16 && wr_16 && rdy_16) begin
            wrdone_16++;
            wr_addr_16 = addr_16;
            wr_data_16 = dout_16;
        end
        if (prev_wait_16 && {addr_16, rd_16, wr_16, dout_16} != prev_bus_16) unstable_16++;
        prev_wait_16 = reset_16 && (rd_16 | wr_16) && !rdy_16;
        prev_bus_16  = {addr_16, rd_16, wr_16, dout_16};
    end

    // ---------------- 8-bit core ----------------
    logic       reset_8;
    logic [7:0] din_8, dout_8;
    logic       rdy_8, rd_8, wr_8, halted_8;
    logic [3:0] addr_8;
    logic [7:0] mem8 [0:15];

    mu0_param #(.DATA_W(8), .RESET_VECTOR(4'hC)) dut8 (
        .Clk(clk), .Reset(reset_8), .Data_in(din_8), .Mem_ready(rdy_8),
        .Rd(rd_8), .Wr(wr_8), .Addr(addr_8), .Data_out(dout_8),
        .Halted(halted_8)
    );

    assign rdy_8 = rd_8 | wr_8;
    assign din_8 = mem8[addr_8];

    int         wrdone_8 = 0, wrcyc_8 = 0, both_8 = 0;
    logic [3:0] wr_addr_8 = '0;
    logic [7:0] wr_data_8 = '0;

    always @(negedge clk) begin
        #1;
        if (rd_8 && wr_8) both_8++;
        if (wr_8) wrcyc_8++;
        if (reset_8 && wr_8 && rdy_8) begin
            wrdone_8++;
            wr_addr_8 = addr_8;
            wr_data_8 = dout_8;
        end
    end

    // ---------------- helpers ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear16();
        for (int i = 0; i < 4096; i++) mem16[i] = 16'h0000;
    endtask

    task automatic reset16();
        @(negedge clk) reset_16 = 1'b0;
        @(negedge clk) reset_16 = 1'b1;
    endtask

    task automatic reset8();
        @(negedge clk) reset_8 = 1'b0;
        @(negedge clk) reset_8 = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run16(input int limit, output int cyc);
        cyc = 0;
        while (!halted_16 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run8(input int limit, output int cyc);
        cyc = 0;
        while (!halted_8 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic load_basic16();
        clear16();
        mem16[12'h010] = 16'h0100;   // LDA 0x100
        mem16[12'h011] = 16'h2101;   // ADD 0x101
        mem16[12'h012] = 16'h1102;   // STA 0x102
        mem16[12'h013] = 16'h7000;   // STP
        mem16[12'h100] = 16'h7FFF;
        mem16[12'h101] = 16'h0001;
    endtask

    int cyc, wd0, wc0, us0, n;

    initial begin
        reset_16 = 1'b0;
        reset_8  = 1'b0;
        for (int i = 0; i < 16; i++) mem8[i] = 8'h00;
        cycles(2);

        // reset state and the basic program with zero wait states
        load_basic16();
        wait_16 = 0;
        reset16();
        check_val("rst_rd",     rd_16,     1);
        check_val("rst_wr",     wr_16,     0);
        check_val("rst_addr",   addr_16,   12'h010);
        check_val("rst_dout",   dout_16,   16'h0000);
        check_val("rst_halted", halted_16, 0);
        wd0 = wrdone_16; wc0 = wrcyc_16;
        run16(200, cyc);
        check_val("basic_halt_cycle", cyc, 8);
        check_val("basic_writes",     wrdone_16 - wd0, 1);
        check_val("basic_wr_cycles",  wrcyc_16 - wc0, 1);
        check_val("basic_wr_addr",    wr_addr_16, 12'h102);
        check_val("basic_wr_data",    wr_data_16, 16'h8000);
        check_val("basic_halt_pc",    addr_16, 12'h014);
        check_val("basic_halt_dout",  dout_16, 16'h8000);

        // three wait cycles on each of the seven memory accesses
        wait_16 = 3;
        reset16();
        wd0 = wrdone_16; wc0 = wrcyc_16; us0 = unstable_16;
        run16(400, cyc);
        check_val("wait_halt_cycle", cyc, 8 + 7 * 3);
        check_val("wait_writes",     wrdone_16 - wd0, 1);
        check_val("wait_wr_cycles",  wrcyc_16 - wc0, 4);
        check_val("wait_wr_data",    wr_data_16, 16'h8000);
        check_val("wait_wr_addr",    wr_addr_16, 12'h102);
        check_val("wait_stable",     unstable_16 - us0, 0);
        wait_16 = 0;

        // JNE not taken on Acc=0
        clear16();
        mem16[12'h010] = 16'hA000; mem16[12'h011] = 16'h6050;
        mem16[12'h012] = 16'h7000; mem16[12'h050] = 16'h7000;
        reset16();
        run16(200, cyc);
        check_val("jne_nt_pc", addr_16, 12'h013);

        // JGE not taken on Acc=0xFFFF
        clear16();
        mem16[12'h010] = 16'hA000; mem16[12'h011] = 16'h3101;
        mem16[12'h012] = 16'h5050; mem16[12'h013] = 16'h7000;
        mem16[12'h050] = 16'h7000; mem16[12'h101] = 16'h0001;
        reset16();
        run16(200, cyc);
        check_val("jge_nt_pc",  addr_16, 12'h014);
        check_val("jge_nt_acc", dout_16, 16'hFFFF);

        // JGE taken on Acc=1
        clear16();
        mem16[12'h010] = 16'hA001; mem16[12'h011] = 16'h5050;
        mem16[12'h012] = 16'h7000; mem16[12'h050] = 16'h7000;
        reset16();
        cycles(4);
        check_val("jge_t_fetch_addr", addr_16, 12'h050);
        check_val("jge_t_fetch_rd",   rd_16,   1);
        run16(200, cyc);
        check_val("jge_t_halt_pc", addr_16, 12'h051);
        check_val("jge_t_acc",     dout_16, 16'h0001);

        // LDI / AND / OR / SHL / NOP
        clear16();
        mem16[12'h010] = 16'hAABC; mem16[12'h011] = 16'h8103;
        mem16[12'h012] = 16'h9104; mem16[12'h013] = 16'hB000;
        mem16[12'h014] = 16'hE123; mem16[12'h015] = 16'h7000;
        mem16[12'h103] = 16'h0F0F; mem16[12'h104] = 16'hF000;
        reset16();
        cycles(2);  check_val("ldi_acc", dout_16, 16'h0ABC);
        cycles(2);  check_val("and_acc", dout_16, 16'h0A0C);
        cycles(2);  check_val("or_acc",  dout_16, 16'hFA0C);
        cycles(2);  check_val("shl_acc", dout_16, 16'hF418);
        cycles(2);
        check_val("nop_acc", dout_16, 16'hF418);
        check_val("nop_pc",  addr_16, 12'h015);
        run16(200, cyc);
        check_val("ops_halt_cycle", cyc, 2);
        check_val("ops_halt_pc",    addr_16, 12'h016);

        // reset while STA is waiting for Mem_ready
        clear16();
        mem16[12'h010] = 16'hA055; mem16[12'h011] = 16'h1105;
        mem16[12'h012] = 16'h7000;
        wait_16 = 5;
        reset16();
        wd0 = wrdone_16;
        n = 0;
        while (!wr_16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("sta_wr_seen", wr_16, 1);
        @(negedge clk);
        check_val("sta_wr_held", wr_16,   1);
        check_val("sta_addr",    addr_16, 12'h105);
        check_val("sta_dout",    dout_16, 16'h0055);
        reset16();
        wait_16 = 0;
        check_val("midrst_rd",     rd_16,   1);
        check_val("midrst_wr",     wr_16,   0);
        check_val("midrst_addr",   addr_16, 12'h010);
        check_val("midrst_dout",   dout_16, 16'h0000);
        check_val("midrst_writes", wrdone_16 - wd0, 0);
        run16(200, cyc);
        check_val("rerun_halt_cycle", cyc, 6);
        check_val("rerun_writes",     wrdone_16 - wd0, 1);
        check_val("rerun_wr_data",    wr_data_16, 16'h0055);
        check_val("rd_wr_exclusive16", both_16, 0);

        // 8-bit core: program straddles the PC wrap 0xF -> 0x0
        mem8[4'hC] = 8'h08;   // LDA 8
        mem8[4'hD] = 8'h29;   // ADD 9
        mem8[4'hE] = 8'h1A;   // STA A
        mem8[4'hF] = 8'hC0;   // NOP
        mem8[4'h0] = 8'h70;   // STP
        mem8[4'h8] = 8'h7F;
        mem8[4'h9] = 8'h01;
        reset8();
        check_val("w8_rst_rd",     rd_8,     1);
        check_val("w8_rst_addr",   addr_8,   4'hC);
        check_val("w8_rst_dout",   dout_8,   8'h00);
        check_val("w8_rst_halted", halted_8, 0);
        wd0 = wrdone_8; wc0 = wrcyc_8;
        cycles(8);
        check_val("w8_wrap_addr", addr_8, 4'h0);
        check_val("w8_wrap_rd",   rd_8,   1);
        run8(200, cyc);
        check_val("w8_halt_cycle", 8 + cyc, 10);
        check_val("w8_halt_pc",    addr_8, 4'h1);
        check_val("w8_acc",        dout_8, 8'h80);
        check_val("w8_writes",     wrdone_8 - wd0, 1);
        check_val("w8_wr_cycles",  wrcyc_8 - wc0, 1);
        check_val("w8_wr_addr",    wr_addr_8, 4'hA);
        check_val("w8_wr_data",    wr_data_8, 8'h80);
        check_val("rd_wr_exclusive8", both_8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
